// File: rtl/datapath_pkg.sv
// Shared datapath definitions: operand-stage FSM states, B-path shift encodings
// and the ALU opcode values used by both the operand stage and the ALU.
package datapath_pkg;

  localparam int DATA_W = 16;
  localparam int NREGS  = 8;
  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD_A = 2'b01,
    RD_B = 2'b10,
    HOLD = 2'b11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_AND   = 2'b10;
  localparam logic [1:0] ALU_NOT_B = 2'b11;

endpackage

// File: rtl/regfile_1r1w.sv
// Register file with one combinational read port and one write port.
// A same-index write bypasses to the read port (write-first); reset clears all entries.
module regfile_1r1w #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

endmodule

// File: rtl/operand_fetch.sv
// Operand stage ahead of the ALU: reads Rn then Rm over one read port, applies
// the B-path shifter and asel/bsel muxes, and hands Ain/Bin/ALUop over valid/ready.
module operand_fetch
  import datapath_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] rn,
  input  logic [REG_AW-1:0] rm,
  input  logic [1:0]        shift,
  input  logic              asel,
  input  logic              bsel,
  input  logic [DATA_W-1:0] sximm5,
  input  logic [1:0]        alu_op_in,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_num,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] Ain,
  output logic [DATA_W-1:0] Bin,
  output logic [1:0]        ALUop,
  output logic              out_valid,
  input  logic              out_ready,
  output state_t            dbg_state
);

  // Handshake: a transfer happens on any rising edge where valid && ready are both
  // high; a producer holds its payload stable from raising valid until that edge.

  state_t            state, state_nxt;
  logic [REG_AW-1:0] cap_rn, cap_rm;
  shift_t            cap_shift;
  logic              cap_asel, cap_bsel;
  logic [DATA_W-1:0] cap_imm;
  logic [1:0]        cap_op;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] shifted;

  regfile_1r1w #(
    .DATA_W(DATA_W),
    .NREGS (NREGS),
    .REG_AW(REG_AW)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wb_en),
    .wr_addr(wb_num),
    .wr_data(wb_data)
  );

  // The single read port serves Rn during RD_A and Rm during RD_B.
  assign rd_addr = (state == RD_B) ? cap_rm : cap_rn;

  always_comb begin
    shifted = rd_data;
    case (cap_shift)
      SH_LSL:  shifted = {rd_data[DATA_W-2:0], 1'b0};
      SH_LSR:  shifted = {1'b0, rd_data[DATA_W-1:1]};
      SH_ASR:  shifted = {rd_data[DATA_W-1], rd_data[DATA_W-1:1]};
      default: shifted = rd_data;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RD_A;
      RD_A:    state_nxt = RD_B;
      RD_B:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cap_rn    <= '0;
      cap_rm    <= '0;
      cap_shift <= SH_NONE;
      cap_asel  <= 1'b0;
      cap_bsel  <= 1'b0;
      cap_imm   <= '0;
      cap_op    <= '0;
      Ain       <= '0;
      Bin       <= '0;
      ALUop     <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        cap_rn    <= rn;
        cap_rm    <= rm;
        cap_shift <= shift_t'(shift);
        cap_asel  <= asel;
        cap_bsel  <= bsel;
        cap_imm   <= sximm5;
        cap_op    <= alu_op_in;
      end
      if (state == RD_A) Ain <= cap_asel ? '0 : rd_data;
      if (state == RD_B) begin
        Bin   <= cap_bsel ? cap_imm : shifted;
        ALUop <= cap_op;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign dbg_state = state;

endmodule
